// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: phases FETCH/DECODE/REGREAD/EXECUTE/WRITEBACK, owns PC.
// Latency: 5 cycles per instruction with zero-wait fetch, +1 per imem_ack wait cycle.
// Backpressure: FETCH stalls until imem_ack; TIMEOUT consecutive unacked cycles halt with fault.
module mc_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter int              TIMEOUT  = 15,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             halt_req,
    input  logic             instr_inv,
    input  logic             pc_load,
    input  logic [PC_W-1:0]  pc_target,
    input  logic             wb_en,
    output logic [2:0]       state,
    output logic [PC_W-1:0]  pc,
    output logic             rf_we,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_REGREAD   = 3'd3,
        S_EXECUTE   = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    // Wait counter must hold TIMEOUT-1; one extra bit of headroom keeps TIMEOUT=1 legal.
    localparam int              WC_W      = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    state_t           st;
    logic [WC_W-1:0]  wait_cnt;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  next_pc;
    logic             wb_q;
    logic             fault_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] cycles_q;

    // All outputs are decodes of registered state, so reset clears them without a clock edge.
    assign state    = st;
    assign pc       = pc_q;
    assign imem_req = (st == S_FETCH);
    assign rf_we    = (st == S_WRITEBACK) && wb_q;
    assign halted   = (st == S_HALT);
    assign fault    = fault_q;
    assign retired  = retired_q;
    assign cycles   = cycles_q;

    // Phase sequencing, PC ownership, fetch timeout and retire accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            wait_cnt  <= '0;
            pc_q      <= PC_RESET;
            next_pc   <= PC_RESET;
            wb_q      <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (start) begin
                        st       <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (imem_ack) begin
                        st <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        st      <= S_HALT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_DECODE: begin
                    st <= halt_req ? S_HALT : S_REGREAD;
                end
                S_REGREAD: begin
                    st <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    // Invalid instruction aborts before any PC or writeback side effect.
                    if (instr_inv) begin
                        st      <= S_HALT;
                        fault_q <= 1'b1;
                    end else begin
                        next_pc <= pc_load ? pc_target : pc_q + PC_W'(1);
                        wb_q    <= wb_en;
                        st      <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    pc_q     <= next_pc;
                    wb_q     <= 1'b0;
                    wait_cnt <= '0;
                    if (retired_q != '1) begin
                        retired_q <= retired_q + CNT_W'(1);
                    end
                    st <= S_FETCH;
                end
                S_HALT: begin
                    st <= S_HALT;
                end
                default: begin
                    st <= S_HALT;
                end
            endcase
        end
    end

    // Saturating count of cycles spent in the active phases FETCH..WRITEBACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= '0;
        end else if ((st >= S_FETCH) && (st <= S_WRITEBACK) && (cycles_q != '1)) begin
            cycles_q <= cycles_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: table of instruction records, hand-written corner sequences,
// and randomized instruction streams checked against an instruction-level model.
module tb_mc_sequencer;

    localparam int PC_W    = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             imem_req;
    logic             imem_ack = 1'b0;
    logic             halt_req = 1'b0;
    logic             instr_inv = 1'b0;
    logic             pc_load = 1'b0;
    logic [PC_W-1:0]  pc_target = '0;
    logic             wb_en = 1'b0;
    logic [2:0]       state;
    logic [PC_W-1:0]  pc;
    logic             rf_we;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] cycles;

    mc_sequencer #(.PC_W(PC_W), .PC_RESET(8'h00), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req), .imem_ack(imem_ack),
        .halt_req(halt_req), .instr_inv(instr_inv), .pc_load(pc_load), .pc_target(pc_target),
        .wb_en(wb_en), .state(state), .pc(pc), .rf_we(rf_we), .halted(halted), .fault(fault),
        .retired(retired), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model: current PC, retired count, active-cycle count, sticky fault.
    int m_pc, m_ret, m_cyc, m_fault;

    typedef struct {
        int d;       // fetch wait cycles before ack
        bit hlt;     // halt_req in DECODE
        bit inv;     // instr_inv in EXECUTE
        bit pcl;     // pc_load in EXECUTE
        int tgt;     // pc_target
        bit wb;      // wb_en
        int exp_pc;  // pc after the instruction (or frozen pc on halt)
        bit exp_hlt; // instruction ends in HALT
        bit exp_flt; // fault expected
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; imem_ack = 0; halt_req = 0; instr_inv = 0; pc_load = 0; pc_target = '0; wb_en = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_flags", {rf_we, halted, fault}, 0);
        chk("rst_counters", retired + cycles, 0);
        step(); step();
        rst_n = 1;
        step();
        chk("idle_hold", state, 0);
        m_pc = 0; m_ret = 0; m_cyc = 0; m_fault = 0;
    endtask

    task automatic do_start();
        start = 1;
        step();
        start = 0;
        chk("start_fetch", state, 1);
        chk("start_cycles", cycles, 0);
    endtask

    // Execute one instruction from FETCH, checking each phase; stopped=1 if it ends in HALT.
    task automatic run_instr(input int d, input bit hlt, input bit inv, input bit pcl,
                             input int tgt, input bit wb, input bit rnd_start, output bit stopped);
        int nf;
        stopped = 0;
        nf = (d < TIMEOUT) ? d + 1 : TIMEOUT;
        for (int i = 0; i < nf; i++) begin
            chk("fetch_state", state, 1);
            chk("fetch_req", imem_req, 1);
            chk("fetch_pc", pc, m_pc);
            imem_ack = (i == d);
            start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            m_cyc++;
        end
        imem_ack = 0;
        if (d >= TIMEOUT) begin
            m_fault = 1;
            stopped = 1;
            chk("timeout_state", state, 6);
            chk("timeout_fault", fault, 1);
            chk("timeout_halted", halted, 1);
            chk("timeout_retired", retired, m_ret);
            chk("timeout_cycles", cycles, m_cyc);
            return;
        end
        chk("decode_state", state, 2);
        chk("decode_req", imem_req, 0);
        halt_req = hlt;
        step();
        m_cyc++;
        halt_req = 0;
        if (hlt) begin
            stopped = 1;
            chk("halt_state", state, 6);
            chk("halt_fault", fault, 0);
            chk("halt_retired", retired, m_ret);
            chk("halt_cycles", cycles, m_cyc);
            return;
        end
        chk("regread_state", state, 3);
        step();
        m_cyc++;
        chk("execute_state", state, 4);
        chk("execute_pc", pc, m_pc);
        instr_inv = inv; pc_load = pcl; pc_target = PC_W'(tgt); wb_en = wb;
        step();
        m_cyc++;
        instr_inv = 0; pc_load = 0; pc_target = '0; wb_en = 0;
        if (inv) begin
            m_fault = 1;
            stopped = 1;
            chk("inv_state", state, 6);
            chk("inv_fault", fault, 1);
            chk("inv_pc", pc, m_pc);
            chk("inv_rf_we", rf_we, 0);
            chk("inv_retired", retired, m_ret);
            return;
        end
        chk("wb_state", state, 5);
        chk("wb_rf_we", rf_we, wb);
        chk("wb_pc", pc, m_pc);
        step();
        m_cyc++;
        m_ret++;
        m_pc = pcl ? tgt : (m_pc + 1) % 256;
        chk("next_state", state, 1);
        chk("next_pc", pc, m_pc);
        chk("rf_we_pulse", rf_we, 0);
        chk("retired", retired, m_ret);
        chk("cycles", cycles, m_cyc);
        chk("no_fault", {halted, fault}, 0);
    endtask

    // In HALT everything is frozen regardless of inputs.
    task automatic hold_halt(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom_range(0, 1)); imem_ack = 1'($urandom_range(0, 1));
            halt_req = 1'($urandom_range(0, 1)); pc_load = 1'($urandom_range(0, 1));
            wb_en = 1'($urandom_range(0, 1)); pc_target = PC_W'($urandom_range(0, 255));
            step();
            chk("halt_frozen_state", state, 6);
            chk("halt_frozen_pc", pc, m_pc);
            chk("halt_frozen_ret", retired, m_ret);
            chk("halt_frozen_cyc", cycles, m_cyc);
            chk("halt_frozen_flags", {halted, fault, rf_we, imem_req}, {1'b1, m_fault[0], 2'b00});
        end
        clear_inputs();
    endtask

    initial begin
        bit stopped;
        int watchdog;
        vecs[0] = '{d: 0,  hlt: 0, inv: 0, pcl: 0, tgt: 0,    wb: 1, exp_pc: 1,    exp_hlt: 0, exp_flt: 0};
        vecs[1] = '{d: 0,  hlt: 0, inv: 0, pcl: 0, tgt: 0,    wb: 1, exp_pc: 2,    exp_hlt: 0, exp_flt: 0};
        vecs[2] = '{d: 0,  hlt: 0, inv: 0, pcl: 0, tgt: 0,    wb: 1, exp_pc: 3,    exp_hlt: 0, exp_flt: 0};
        vecs[3] = '{d: 3,  hlt: 0, inv: 0, pcl: 0, tgt: 0,    wb: 0, exp_pc: 4,    exp_hlt: 0, exp_flt: 0};
        vecs[4] = '{d: 0,  hlt: 0, inv: 0, pcl: 1, tgt: 'h40, wb: 1, exp_pc: 'h40, exp_hlt: 0, exp_flt: 0};
        vecs[5] = '{d: 1,  hlt: 0, inv: 0, pcl: 1, tgt: 'hFF, wb: 0, exp_pc: 'hFF, exp_hlt: 0, exp_flt: 0};
        vecs[6] = '{d: 0,  hlt: 0, inv: 0, pcl: 0, tgt: 0,    wb: 1, exp_pc: 'h00, exp_hlt: 0, exp_flt: 0};
        vecs[7] = '{d: 14, hlt: 0, inv: 0, pcl: 0, tgt: 0,    wb: 0, exp_pc: 'h01, exp_hlt: 0, exp_flt: 0};
        vecs[8] = '{d: 0,  hlt: 0, inv: 0, pcl: 1, tgt: 'h80, wb: 1, exp_pc: 'h80, exp_hlt: 0, exp_flt: 0};
        vecs[9] = '{d: 2,  hlt: 0, inv: 1, pcl: 1, tgt: 'h22, wb: 1, exp_pc: 'h80, exp_hlt: 1, exp_flt: 1};

        // Table-driven instruction stream, start pulses ignored while running.
        do_reset();
        do_start();
        for (int v = 0; v < 10; v++) begin
            run_instr(vecs[v].d, vecs[v].hlt, vecs[v].inv, vecs[v].pcl, vecs[v].tgt,
                      vecs[v].wb, 1'b1, stopped);
            chk("vec_pc", pc, vecs[v].exp_pc);
            chk("vec_halted", halted, vecs[v].exp_hlt);
            chk("vec_fault", fault, vecs[v].exp_flt);
            if (v == 2) begin
                chk("three_instr_retired", retired, 3);
                chk("three_instr_cycles", cycles, 15);
            end
            if (v == 3) chk("delayed_ack_cycles", cycles, 23);
        end
        hold_halt(3);

        // Fetch timeout with ack held low.
        do_reset();
        do_start();
        run_instr(0, 0, 0, 0, 0, 1, 1'b0, stopped);
        run_instr(TIMEOUT, 0, 0, 0, 0, 1, 1'b0, stopped);
        chk("timeout_stopped", stopped, 1);
        chk("timeout_cycles_total", cycles, 5 + TIMEOUT);
        hold_halt(2);

        // Async reset mid-fetch drops imem_req without a clock edge.
        do_reset();
        do_start();
        #2;
        chk("pre_rst_req", imem_req, 1);
        rst_n = 0;
        #1;
        chk("async_rst_req", imem_req, 0);
        chk("async_rst_state", state, 0);
        #1;
        rst_n = 1;
        m_pc = 0; m_ret = 0; m_cyc = 0; m_fault = 0;
        step();
        chk("post_rst_idle", state, 0);
        do_start();
        chk("refetch_pc", pc, 0);
        run_instr(1, 0, 0, 0, 0, 1, 1'b0, stopped);
        run_instr(0, 1, 0, 0, 0, 1, 1'b0, stopped);
        chk("halt_req_retired", retired, 1);
        hold_halt(2);

        // Randomized instruction streams against the model.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            do_start();
            watchdog = 0;
            stopped = 0;
            while (!stopped && watchdog < 40) begin
                int d;
                d = ($urandom_range(0, 24) == 0) ? TIMEOUT + $urandom_range(0, 1) : $urandom_range(0, 4);
                run_instr(d, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
                          1'($urandom_range(0, 1)), $urandom_range(0, 255),
                          1'($urandom_range(0, 1)), 1'b1, stopped);
                watchdog++;
            end
            if (stopped) hold_halt(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
